range_normalizer: RTL and testbench

Iterative input range reducer for the approximation datapath. It shifts an unsigned operand by powers of two until the value lands inside the window [LO, HI]. It returns the normalised value together with a signed shift count, so downstream logic can undo the scaling. Successor to the single-step scaler: multi-step, parametrised window and width, valid/ready handshake, saturation reporting.

---
 rtl/range_norm_pkg.sv | 29 ++
 rtl/norm_shift_step.sv | 20 ++
 rtl/range_normalizer.sv | 154 +++++++++++++++
 tb/tb_range_normalizer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/range_norm_pkg.sv
// Shared definitions for the range normaliser: FSM/lock encodings, default
// window parameters and the signed shift-count width helper.
package range_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Once a direction has been taken the opposite one is forbidden; this
  // is what bounds the iteration without relying on MAX_SHIFT alone.
  typedef enum logic [1:0] {
    LOCK_NONE  = 2'd0,
    LOCK_LEFT  = 2'd1,
    LOCK_RIGHT = 2'd2
  } lock_e;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_LO        = 12;
  localparam int unsigned DEF_HI        = 20;
  localparam int unsigned DEF_MAX_SHIFT = 7;

  // Magnitude bits for 0..max_shift plus one sign bit.
  function automatic int unsigned sw_width(input int unsigned max_shift);
    return $clog2(max_shift + 1) + 1;
  endfunction

endpackage

// File: rtl/norm_shift_step.sv
// Single power-of-two step: left shift by one, or right shift by one with
// optional round-half-up. Purely combinational.
module norm_shift_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] v_i,
  input  logic         dir_right_i,
  input  logic         round_en_i,
  output logic [W-1:0] v_o
);

  logic [W-1:0] half;
  logic [W-1:0] rnd;

  // (v>>1) + v[0] never overflows: v>>1 is at most 2^(W-1)-1.
  assign half = v_i >> 1;
  assign rnd  = W'(round_en_i & v_i[0]);
  assign v_o  = dir_right_i ? (half + rnd) : {v_i[W-2:0], 1'b0};

endmodule

// File: rtl/range_normalizer.sv
// Iterative range reducer: shifts an unsigned operand by powers of two until
// it lands in [LO, HI], reporting a signed shift count and saturation.
// Build option: define RANGE_NORMALIZER_ROUND_EN to round right shifts half up
// instead of truncating.
module range_normalizer
  import range_norm_pkg::*;
#(
  parameter  int unsigned W         = DEF_W,
  parameter  int unsigned LO        = DEF_LO,
  parameter  int unsigned HI        = DEF_HI,
  parameter  int unsigned MAX_SHIFT = DEF_MAX_SHIFT,
  localparam int unsigned SW        = sw_width(MAX_SHIFT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  x_scaled_o,
  output logic [SW-1:0] shift_cnt_o,
  output logic          sat_o
);

`ifdef RANGE_NORMALIZER_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic [W-1:0]  LO_V  = W'(LO);
  localparam logic [W-1:0]  HI_V  = W'(HI);
  localparam logic [SW-1:0] MAX_V = SW'(MAX_SHIFT);
  localparam logic [SW-1:0] ONE   = SW'(1);

  state_e        state_q, state_d;
  lock_e         lock_q, lock_d;
  logic [W-1:0]  v_q, v_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  xo_q, xo_d;
  logic [SW-1:0] co_q, co_d;
  logic          sat_q, sat_d;
  logic          ov_q, ov_d;
  logic          ir_q, ir_d;

  logic          need_right;
  logic          need_left;
  logic [SW-1:0] cnt_abs;
  logic          at_limit;
  logic [W-1:0]  step_v;

  // Shift requirements for the current working value, honouring the lock.
  assign need_right = (v_q > HI_V) && (lock_q != LOCK_LEFT);
  assign need_left  = (v_q < LO_V) && (lock_q != LOCK_RIGHT);
  assign cnt_abs    = cnt_q[SW-1] ? (~cnt_q + ONE) : cnt_q;
  assign at_limit   = (cnt_abs == MAX_V);

  norm_shift_step #(
    .W (W)
  ) u_step (
    .v_i         (v_q),
    .dir_right_i (need_right),
    .round_en_i  (ROUND_EN),
    .v_o         (step_v)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    xo_d    = xo_q;
    co_d    = co_q;
    sat_d   = sat_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && ir_q) begin
          v_d     = x_i;
          cnt_d   = '0;
          lock_d  = LOCK_NONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (v_q == '0) begin
          xo_d    = '0;
          co_d    = '0;
          sat_d   = 1'b1;
          state_d = DONE;
        end else if (need_right || need_left) begin
          if (at_limit) begin
            xo_d    = v_q;
            co_d    = cnt_q;
            sat_d   = 1'b1;
            state_d = DONE;
          end else begin
            v_d    = step_v;
            cnt_d  = need_right ? (cnt_q - ONE) : (cnt_q + ONE);
            lock_d = need_right ? LOCK_RIGHT : LOCK_LEFT;
          end
        end else begin
          xo_d    = v_q;
          co_d    = cnt_q;
          sat_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ov_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ov_d = (state_d == DONE);
    ir_d = (state_d == IDLE);
  end

  // State and output registers; reset discards any operand in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= LOCK_NONE;
      v_q     <= '0;
      cnt_q   <= '0;
      xo_q    <= '0;
      co_q    <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      xo_q    <= xo_d;
      co_q    <= co_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
    end
  end

  assign in_ready    = ir_q;
  assign out_valid   = ov_q;
  assign x_scaled_o  = xo_q;
  assign shift_cnt_o = co_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_range_normalizer.sv
// Bench for range_normalizer: default instance (MAX_SHIFT=7) plus a
// MAX_SHIFT=2 instance for shift-limit saturation.
module tb_range_normalizer;

  logic clk;
  logic rst;

  logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, sat_a;
  logic [7:0] x_a, xs_a;
  logic [3:0] cnt_a;

  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, sat_b;
  logic [7:0] x_b, xs_b;
  logic [2:0] cnt_b;

  typedef struct {
    logic [7:0] x;
    int         ex;
    int         ecnt;
    int         esat;
    int         elat;
  } vec_t;

  typedef struct {
    int x;
    int ex;
    int ecnt;
    int esat;
    int elat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_tests = 0;
  int   n_fail  = 0;

  range_normalizer dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .x_i         (x_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready_a),
    .x_scaled_o  (xs_a),
    .shift_cnt_o (cnt_a),
    .sat_o       (sat_a)
  );

  range_normalizer #(.MAX_SHIFT(2)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .x_i         (x_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready_b),
    .x_scaled_o  (xs_b),
    .shift_cnt_o (cnt_b),
    .sat_o       (sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  function automatic int rdy(input int d);
    return (d == 0) ? int'(in_ready_a) : int'(in_ready_b);
  endfunction

  function automatic int ov(input int d);
    return (d == 0) ? int'(out_valid_a) : int'(out_valid_b);
  endfunction

  function automatic int xs(input int d);
    return (d == 0) ? int'(xs_a) : int'(xs_b);
  endfunction

  function automatic int cnt(input int d);
    int a, b;
    a = int'($signed(cnt_a));
    b = int'($signed(cnt_b));
    return (d == 0) ? a : b;
  endfunction

  function automatic int sat(input int d);
    return (d == 0) ? int'(sat_a) : int'(sat_b);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [7:0] x);
    if (d == 0) begin
      in_valid_a = v;
      x_a        = x;
    end else begin
      in_valid_b = v;
      x_b        = x;
    end
  endtask

  // Drive one operand, push its expectation, pop and compare at out_valid.
  task automatic apply(input int d, input logic [7:0] x, input int ex,
                       input int ecnt, input int esat, input int elat);
    int   edges;
    exp_t e;
    exp_t g;
    edges = 0;
    while (rdy(d) == 0 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check($sformatf("in_ready_before x=%0d dut%0d", x, d), rdy(d), 1);
    set_in(d, 1'b1, x);
    e = '{int'(x), ex, ecnt, esat, elat};
    sb.push_back(e);
    @(posedge clk); #1;
    set_in(d, 1'b0, 8'd0);
    edges = 0;
    while (ov(d) == 0 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (ov(d) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout x=%0d dut%0d: out_valid never rose", x, d);
    end
    g = sb.pop_front();
    check($sformatf("latency x=%0d dut%0d", g.x, d), edges, g.elat);
    check($sformatf("x_scaled x=%0d dut%0d", g.x, d), xs(d), g.ex);
    check($sformatf("shift_cnt x=%0d dut%0d", g.x, d), cnt(d), g.ecnt);
    check($sformatf("sat x=%0d dut%0d", g.x, d), sat(d), g.esat);
    @(posedge clk); #1;
    check($sformatf("out_valid_drop x=%0d dut%0d", g.x, d), ov(d), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; x_a = 8'd0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; x_b = 8'd0; out_ready_b = 1'b1;

    // Window [12,20], MAX_SHIFT=7; rounding changes only right-shift cases.
    vecs[0]  = '{8'd16,  16, 0, 0, 1};
    vecs[1]  = '{8'd3,   12, 2, 0, 3};
`ifdef RANGE_NORMALIZER_ROUND_EN
    vecs[2]  = '{8'd200, 13, -4, 0, 5};
    vecs[6]  = '{8'd21,  11, -1, 0, 2};
    vecs[9]  = '{8'd255, 16, -4, 0, 5};
    vecs[10] = '{8'd41,  11, -2, 0, 3};
`else
    vecs[2]  = '{8'd200, 12, -4, 0, 5};
    vecs[6]  = '{8'd21,  10, -1, 0, 2};
    vecs[9]  = '{8'd255, 15, -4, 0, 5};
    vecs[10] = '{8'd41,  20, -1, 0, 2};
`endif
    vecs[3]  = '{8'd0,    0, 0, 1, 1};
    vecs[4]  = '{8'd12,  12, 0, 0, 1};
    vecs[5]  = '{8'd20,  20, 0, 0, 1};
    vecs[7]  = '{8'd1,   16, 4, 0, 5};
    vecs[8]  = '{8'd11,  22, 1, 0, 2};
    vecs[11] = '{8'd2,   16, 3, 0, 4};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst in_ready", rdy(0), 1);
    check("rst out_valid", ov(0), 0);
    check("rst x_scaled", xs(0), 0);
    check("rst shift_cnt", cnt(0), 0);
    check("rst sat", sat(0), 0);

    foreach (vecs[i])
      apply(0, vecs[i].x, vecs[i].ex, vecs[i].ecnt, vecs[i].esat, vecs[i].elat);

    // Shift-limit saturation and the exact-limit non-saturating case
    apply(1, 8'd1,   4,  2, 1, 3);
    apply(1, 8'd0,   0,  0, 1, 1);
    apply(1, 8'd3,  12,  2, 0, 3);
    apply(1, 8'd200, 50, -2, 1, 3);

    // Back-pressure: result held while out_ready is low
    begin
      int edges;
      out_ready_a = 1'b0;
      set_in(0, 1'b1, 8'd3);
      @(posedge clk); #1;
      set_in(0, 1'b0, 8'd0);
      edges = 0;
      while (ov(0) == 0 && edges < 40) begin
        @(posedge clk); #1;
        edges++;
      end
      check("bp latency", edges, 3);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("bp hold out_valid c%0d", i), ov(0), 1);
        check($sformatf("bp hold in_ready c%0d", i), rdy(0), 0);
        check($sformatf("bp hold x_scaled c%0d", i), xs(0), 12);
        check($sformatf("bp hold shift_cnt c%0d", i), cnt(0), 2);
        check($sformatf("bp hold sat c%0d", i), sat(0), 0);
        @(posedge clk); #1;
      end
      out_ready_a = 1'b1;
      @(posedge clk); #1;
      check("bp release in_ready", rdy(0), 1);
      check("bp release out_valid", ov(0), 0);
    end

    // Reset during SHIFT aborts the operand
    set_in(0, 1'b1, 8'd200);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", rdy(0), 1);
    check("abort out_valid", ov(0), 0);
    check("abort x_scaled", xs(0), 0);
    check("abort shift_cnt", cnt(0), 0);
    check("abort sat", sat(0), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort no output", ov(0), 0);
    apply(0, 8'd16, 16, 0, 0, 1);

    check("scoreboard empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
